simplerisc_instr_encoder: RTL
=============================

// Module: simplerisc_instr_encoder
// PURPOSE
//   Encoder counterpart of the opcode decoder: takes instruction fields (opcode, I, modifiers, registers,
//   immediate/offset) over a valid/ready stream and packs them into 32-bit SimpleRISC words.
//   Writes each word to instruction memory at sequential word addresses.
//   Used as the program loader in front of the fetch stage and as the bench stimulus source for the core.
// PARAMETERS
//   ADDR_W     8    instruction-memory word-address width
//   DEPTH      256  words the loader may write per load, 1..2**ADDR_W
//   BASE_ADDR  0    word address of the first write
// PORTS
//   clk          in   1      clock, rising edge
//   reset        in   1      synchronous, active-high
//   start        in   1      pulse in IDLE: begin a load at BASE_ADDR
//   in_valid     in   1      field bundle valid
//   in_ready     out  1      encoder can accept a bundle
//   in_last      in   1      bundle is the final instruction of the program
//   in_opcode    in   5      opcode, [4] is the MSB; legal 00000..10100
//   in_i         in   1      immediate flag
//   in_mod       in   2      immediate modifier: 00 default, 01 u, 10 h
//   in_rd        in   4      destination register; the source register for st
//   in_rs1       in   4      source register 1
//   in_rs2       in   4      source register 2, used when in_i=0
//   in_imm       in   16     immediate, used when in_i=1
//   in_offset    in   27     branch offset, or absolute target (see CONFIGURATION)
//   imem_we      out  1      one-cycle write strobe
//   imem_addr    out  ADDR_W word address, BASE_ADDR+ptr
//   imem_wdata   out  32     encoded word
//   busy         out  1      state != IDLE
//   done         out  1      one-cycle pulse when a load ends
//   err_illegal  out  1      sticky: an illegal opcode was dropped
//   err_full     out  1      sticky: DEPTH reached before in_last
//   count        out  ADDR_W+1 words written in the current or last load
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; ptr=0; sticky errors cleared.
//   A start pulse also clears ptr, count and both sticky errors.
//   Encoding, format by opcode:
//     - op<=01100, 01110, 01111: {op,I,rd,rs1,I ? {mod,imm} : {rs2,14'b0}}.
//     - cmp (00101): rd field forced to 0.
//     - not/mov (01000/01001): rs1 field forced to 0.
//     - nop (01101) and ret (10100): {op,27'b0}.
//     - beq/bgt/b/call (10000..10011): {op,offset[26:0]}.
//     - Opcodes 10101..11111 are illegal.
//   FSM (transitions on accept = in_valid & in_ready):
//     - IDLE: in_ready=0. start -> LOAD. start is ignored in any other state.
//     - LOAD: in_ready=1. On accept with a legal opcode: latch the encoded word into imem_wdata, go to WRITE.
//       On accept with an illegal opcode: set err_illegal, write nothing; go to DONE if in_last, else stay in LOAD.
//     - WRITE: in_ready=0; imem_we=1 for exactly this cycle; ptr++ and count++ at the end of the cycle.
//       Next state: DONE if the word was last, else DONE with err_full set if ptr+1==DEPTH, else LOAD.
//     - DONE: done=1 for one cycle, then IDLE.
//   Timing: a bundle accepted in cycle N is written in cycle N+1. Peak throughput is one word per 2 cycles.
//   imem_addr and imem_wdata are held stable while imem_we=1 and keep their last values otherwise.
//   Address arithmetic: imem_addr = (BASE_ADDR+ptr) mod 2**ADDR_W.
//   Reset mid-load aborts immediately: no further writes, done is not pulsed, count returns to 0.
//   Inputs are don't-care while in_ready=0.
// CONFIGURATION
//   ENC_ABS_TARGET_EN defined:
//     - For branch opcodes, in_offset is an absolute word target.
//     - Encoded offset = (in_offset - imem_addr) mod 2**27, where imem_addr is the word's own address.
//   ENC_ABS_TARGET_EN undefined: in_offset is copied unchanged into bits [26:0].
// TESTING
//   1. add, rd=1 rs1=2 rs2=3, I=0, last -> one write: addr 0, data 0x0048C000. done pulses; count=1.
//   2. mov rd=5, I=1, mod=00, imm=0xFFFF -> data 0x4D40FFFF.
//      cmp, rd=7 rs1=2 rs2=3 -> data 0x2808C000 (rd field zeroed).
//   3. Stream beq offset 0x10, then ret with last -> writes 0x80000010 @0 and 0xA0000000 @1.
//      imem_we is never high on consecutive cycles.
//   4. Illegal opcode 10110, then add with last -> err_illegal=1.
//      Exactly one write: add @0; count=1.
//   5. DEPTH=4, 5 bundles with no last -> 4 writes @0..3; err_full=1; done pulses.
//      The 5th bundle is not accepted.
//   6. With ENC_ABS_TARGET_EN: b target 0x20 written at addr 4 -> data 0x9000001C.
//      Assert reset during WRITE -> busy=0, count=0 next cycle, no done pulse.

Source files
------------

// File: rtl/simplerisc_instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : simplerisc_instr_encoder_if
// Brief    : Field-bundle valid/ready stream feeding the SimpleRISC encoder.
// Revision : 1.0  initial release
// ============================================================================
interface simplerisc_instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [4:0]  in_opcode;
    logic        in_i;
    logic [1:0]  in_mod;
    logic [3:0]  in_rd;
    logic [3:0]  in_rs1;
    logic [3:0]  in_rs2;
    logic [15:0] in_imm;
    logic [26:0] in_offset;

    modport master (
        output in_valid, in_last, in_opcode, in_i, in_mod,
               in_rd, in_rs1, in_rs2, in_imm, in_offset,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_last, in_opcode, in_i, in_mod,
               in_rd, in_rs1, in_rs2, in_imm, in_offset,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/simplerisc_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : simplerisc_instr_encoder
// Brief    : Packs instruction field bundles into 32-bit SimpleRISC words and
//            writes them to instruction memory at sequential word addresses.
//            Define ENC_ABS_TARGET_EN to treat branch offsets as absolute targets.
// Revision : 1.0  initial release
// ============================================================================
module simplerisc_instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    simplerisc_instr_encoder_if.slave in_if,
    output logic                      imem_we,
    output logic [ADDR_W-1:0]         imem_addr,
    output logic [31:0]               imem_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      err_illegal,
    output logic                      err_full,
    output logic [ADDR_W:0]           count
);

    localparam logic [1:0]      c_ST_IDLE  = 2'd0;
    localparam logic [1:0]      c_ST_LOAD  = 2'd1;
    localparam logic [1:0]      c_ST_WRITE = 2'd2;
    localparam logic [1:0]      c_ST_DONE  = 2'd3;
    localparam logic [ADDR_W:0] c_DEPTH    = (ADDR_W+1)'(DEPTH);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [ADDR_W:0]   r_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_last;
    logic              r_err_illegal;
    logic              r_err_full;

    logic              w_in_ready;
    logic              w_we;
    logic              w_busy;
    logic              w_done;
    logic              w_accept;
    logic              w_legal;
    logic [31:0]       w_enc;
    logic [3:0]        w_rd;
    logic [3:0]        w_rs1;
    logic [26:0]       w_off;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W:0]   w_ptr_inc;

    assign w_addr    = ADDR_W'(BASE_ADDR) + r_ptr[ADDR_W-1:0];
    assign w_ptr_inc = r_ptr + 1'b1;
    assign w_accept  = in_if.in_valid & w_in_ready;

    // The address is the one this word will be written to, so relative
    // branch offsets are computed against the word's own location.
`ifdef ENC_ABS_TARGET_EN
    assign w_off = in_if.in_offset - 27'(w_addr);
`else
    assign w_off = in_if.in_offset;
`endif

    always_comb begin
        w_rd    = (in_if.in_opcode == 5'b00101) ? 4'd0 : in_if.in_rd;
        w_rs1   = ((in_if.in_opcode == 5'b01000) || (in_if.in_opcode == 5'b01001))
                  ? 4'd0 : in_if.in_rs1;
        w_legal = 1'b1;
        w_enc   = 32'd0;
        if ((in_if.in_opcode == 5'b01101) || (in_if.in_opcode == 5'b10100)) begin
            w_enc = {in_if.in_opcode, 27'd0};
        end else if ((in_if.in_opcode <= 5'b01100) || (in_if.in_opcode == 5'b01110) ||
                     (in_if.in_opcode == 5'b01111)) begin
            w_enc = {in_if.in_opcode, in_if.in_i, w_rd, w_rs1,
                     in_if.in_i ? {in_if.in_mod, in_if.in_imm} : {in_if.in_rs2, 14'd0}};
        end else if ((in_if.in_opcode >= 5'b10000) && (in_if.in_opcode <= 5'b10011)) begin
            w_enc = {in_if.in_opcode, w_off};
        end else begin
            w_legal = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_next = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                if (w_accept) begin
                    if (w_legal) begin
                        w_next = c_ST_WRITE;
                    end else if (in_if.in_last) begin
                        w_next = c_ST_DONE;
                    end
                end
            end
            c_ST_WRITE: begin
                if (r_last || (w_ptr_inc == c_DEPTH)) begin
                    w_next = c_ST_DONE;
                end else begin
                    w_next = c_ST_LOAD;
                end
            end
            default: begin
                w_next = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_we       = 1'b0;
        w_busy     = 1'b1;
        w_done     = 1'b0;
        case (r_state)
            c_ST_IDLE:  w_busy     = 1'b0;
            c_ST_LOAD:  w_in_ready = 1'b1;
            c_ST_WRITE: w_we       = 1'b1;
            default:    w_done     = 1'b1;
        endcase
    end

    // Address and data are captured at accept so they stay put through the
    // write strobe and afterwards, even though the pointer moves on.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr         <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_last        <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_full    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_ptr         <= '0;
                        r_err_illegal <= 1'b0;
                        r_err_full    <= 1'b0;
                    end
                end
                c_ST_LOAD: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_wdata <= w_enc;
                            r_addr  <= w_addr;
                            r_last  <= in_if.in_last;
                        end else begin
                            r_err_illegal <= 1'b1;
                        end
                    end
                end
                c_ST_WRITE: begin
                    r_ptr <= w_ptr_inc;
                    if (!r_last && (w_ptr_inc == c_DEPTH)) begin
                        r_err_full <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_if.in_ready = w_in_ready;
    assign imem_we        = w_we;
    assign imem_addr      = r_addr;
    assign imem_wdata     = r_wdata;
    assign busy           = w_busy;
    assign done           = w_done;
    assign err_illegal    = r_err_illegal;
    assign err_full       = r_err_full;
    assign count          = r_ptr;

endmodule
`default_nettype wire
